// File: rtl/axis_ram_switch_rd_sched.sv
// Read-side frame scheduler for one output of the shared-RAM stream switch:
// arbitrates per-source frame commands and expands each into single-word RAM reads.
module axis_ram_switch_rd_sched #(
  parameter int S_COUNT               = 4,
  parameter int ADDR_WIDTH            = 12,
  parameter int LEN_WIDTH             = 12,
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1,
  localparam int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [S_COUNT*LEN_WIDTH-1:0]  s_cmd_len,
  input  logic [S_COUNT-1:0]            s_cmd_valid,
  output logic [S_COUNT-1:0]            s_cmd_ready,
  output logic [ADDR_WIDTH-1:0]         m_rd_addr,
  output logic [IW-1:0]                 m_rd_src,
  output logic                          m_rd_last,
  output logic                          m_rd_valid,
  input  logic                          m_rd_ready,
  output logic                          busy,
  output logic [IW-1:0]                 grant_index
);

  typedef enum logic {IDLE, READ} state_t;

  // The pointer holds the "last granted" index; its reset value makes the
  // first search start at index 0 (ascending) or S_COUNT-1 (descending).
  localparam logic [IW-1:0] PTR_RST = (ARB_LSB_HIGH_PRIORITY != 0) ? IW'(S_COUNT - 1) : '0;

  state_t                  st_q, st_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic [IW-1:0]           src_q;
  logic [IW-1:0]           ptr_q;

  logic [IW-1:0]           base;
  logic [IW-1:0]           cand;
  int                      cand_i;
  logic                    gnt_found;
  logic [IW-1:0]           gnt_idx;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [LEN_WIDTH-1:0]    len_sel;
  logic                    accept;
  logic                    rd_hs;
  logic                    rem_zero;

  assign base     = (ARB_TYPE_ROUND_ROBIN != 0) ? ptr_q : PTR_RST;
  assign rem_zero = (rem_q == '0);
  assign accept   = (st_q == IDLE) && gnt_found;
  assign rd_hs    = (st_q == READ) && m_rd_ready;

  // Circular search starting one step past the base index.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_i    = 0;
    cand      = '0;
    for (int i = 1; i <= S_COUNT; i++) begin
      if (ARB_LSB_HIGH_PRIORITY != 0) cand_i = (int'(base) + i) % S_COUNT;
      else                            cand_i = (int'(base) + S_COUNT - i) % S_COUNT;
      cand = IW'(cand_i);
      if (!gnt_found && s_cmd_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    len_sel  = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      if (gnt_idx == IW'(k)) begin
        addr_sel = s_cmd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        len_sel  = s_cmd_len[k*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (gnt_found) st_d = READ;
      READ:    if (m_rd_ready && rem_zero) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    s_cmd_ready = '0;
    if (accept) s_cmd_ready[gnt_idx] = 1'b1;
    m_rd_valid  = (st_q == READ);
    m_rd_last   = (st_q == READ) && rem_zero;
    busy        = (st_q == READ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      src_q  <= '0;
      ptr_q  <= PTR_RST;
    end else if (accept) begin
      addr_q <= addr_sel;
      rem_q  <= len_sel;
      src_q  <= gnt_idx;
      ptr_q  <= gnt_idx;
    end else if (rd_hs && !rem_zero) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
      rem_q  <= rem_q - LEN_WIDTH'(1);
    end
  end

  assign m_rd_addr   = addr_q;
  assign m_rd_src    = src_q;
  assign grant_index = src_q;

endmodule

// File: tb/tb_axis_ram_switch_rd_sched.sv
// Directed bench for axis_ram_switch_rd_sched: round-robin vector table plus
// frame, wrap, backpressure, mid-frame reset and fixed-priority sequences.
module tb_axis_ram_switch_rd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] s_cmd_addr;
  logic [47:0] s_cmd_len;
  logic [3:0]  s_cmd_valid;
  logic [3:0]  s_cmd_ready;
  logic [11:0] m_rd_addr;
  logic [1:0]  m_rd_src;
  logic        m_rd_last;
  logic        m_rd_valid;
  logic        m_rd_ready;
  logic        busy;
  logic [1:0]  grant_index;

  logic [47:0] fp_addr;
  logic [47:0] fp_len;
  logic [3:0]  fp_valid;
  logic [3:0]  fp_ready;
  logic [11:0] fp_rd_addr;
  logic [1:0]  fp_rd_src;
  logic        fp_rd_last;
  logic        fp_rd_valid;
  logic        fp_busy;
  logic [1:0]  fp_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_ram_switch_rd_sched #(
    .S_COUNT(4), .ADDR_WIDTH(12), .LEN_WIDTH(12),
    .ARB_TYPE_ROUND_ROBIN(1), .ARB_LSB_HIGH_PRIORITY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .m_rd_addr(m_rd_addr), .m_rd_src(m_rd_src), .m_rd_last(m_rd_last),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
    .busy(busy), .grant_index(grant_index)
  );

  axis_ram_switch_rd_sched #(
    .S_COUNT(4), .ADDR_WIDTH(12), .LEN_WIDTH(12),
    .ARB_TYPE_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(1)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .s_cmd_addr(fp_addr), .s_cmd_len(fp_len),
    .s_cmd_valid(fp_valid), .s_cmd_ready(fp_ready),
    .m_rd_addr(fp_rd_addr), .m_rd_src(fp_rd_src), .m_rd_last(fp_rd_last),
    .m_rd_valid(fp_rd_valid), .m_rd_ready(1'b1),
    .busy(fp_busy), .grant_index(fp_grant)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_src;
    logic [11:0] exp_addr;
    logic        exp_last;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; issues one command and checks every word.
  task automatic run_frame(input int src, input logic [11:0] addr, input logic [11:0] len);
    s_cmd_addr[src*12 +: 12] = addr;
    s_cmd_len[src*12 +: 12]  = len;
    s_cmd_valid = 4'(1 << src);
    m_rd_ready  = 1'b1;
    @(negedge clk);
    chk("frame_accept_ready", 32'(s_cmd_ready), 32'(1 << src));
    @(posedge clk); #1;
    s_cmd_valid = 4'h0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      chk("frame_valid", 32'(m_rd_valid), 32'd1);
      chk("frame_addr",  32'(m_rd_addr), 32'((addr + 12'(i)) & 12'hFFF));
      chk("frame_src",   32'(m_rd_src), 32'(src));
      chk("frame_last",  32'(m_rd_last), 32'(i == int'(len)));
      chk("frame_grant", 32'(grant_index), 32'(src));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("frame_end_busy",  32'(busy), 32'd0);
    chk("frame_end_valid", 32'(m_rd_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int hs;
    int acc;
    logic done, prev_stall;
    logic [11:0] prev_addr;
    logic [1:0]  prev_src;
    logic        prev_last;
    logic        pat[4];

    // Round robin, all four sources valid, single-word frames.
    tbl[0]  = '{4'hF, 4'h1, 1'b0, 2'd0, 12'h000, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 4'h0, 1'b1, 2'd0, 12'h100, 1'b1, 2'd0};
    tbl[2]  = '{4'hF, 4'h2, 1'b0, 2'd0, 12'h000, 1'b0, 2'd0};
    tbl[3]  = '{4'hF, 4'h0, 1'b1, 2'd1, 12'h110, 1'b1, 2'd1};
    tbl[4]  = '{4'hF, 4'h4, 1'b0, 2'd0, 12'h000, 1'b0, 2'd1};
    tbl[5]  = '{4'hF, 4'h0, 1'b1, 2'd2, 12'h120, 1'b1, 2'd2};
    tbl[6]  = '{4'hF, 4'h8, 1'b0, 2'd0, 12'h000, 1'b0, 2'd2};
    tbl[7]  = '{4'hF, 4'h0, 1'b1, 2'd3, 12'h130, 1'b1, 2'd3};
    tbl[8]  = '{4'hF, 4'h1, 1'b0, 2'd0, 12'h000, 1'b0, 2'd3};
    tbl[9]  = '{4'hF, 4'h0, 1'b1, 2'd0, 12'h100, 1'b1, 2'd0};
    tbl[10] = '{4'hF, 4'h2, 1'b0, 2'd0, 12'h000, 1'b0, 2'd0};
    tbl[11] = '{4'hF, 4'h0, 1'b1, 2'd1, 12'h110, 1'b1, 2'd1};

    rst = 1'b1;
    s_cmd_addr  = '0;
    s_cmd_len   = '0;
    s_cmd_valid = 4'h0;
    m_rd_ready  = 1'b1;
    fp_addr  = {12'h3A0, 12'h2A0, 12'h1A0, 12'h0A0};
    fp_len   = '0;
    fp_valid = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", 32'(s_cmd_ready), 32'd0);
    chk("rst_valid", 32'(m_rd_valid), 32'd0);
    chk("rst_last",  32'(m_rd_last), 32'd0);
    chk("rst_addr",  32'(m_rd_addr), 32'd0);
    chk("rst_src",   32'(m_rd_src), 32'd0);
    chk("rst_grant", 32'(grant_index), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) s_cmd_addr[k*12 +: 12] = 12'h100 + 12'(16 * k);
    for (int n = 0; n < 12; n++) begin
      s_cmd_valid = tbl[n].valid;
      @(negedge clk);
      chk("rr_ready", 32'(s_cmd_ready), 32'(tbl[n].exp_ready));
      chk("rr_valid", 32'(m_rd_valid), 32'(tbl[n].exp_valid));
      chk("rr_busy",  32'(busy), 32'(tbl[n].exp_valid));
      chk("rr_last",  32'(m_rd_last), 32'(tbl[n].exp_last));
      chk("rr_grant", 32'(grant_index), 32'(tbl[n].exp_grant));
      if (tbl[n].exp_valid) begin
        chk("rr_src",  32'(m_rd_src), 32'(tbl[n].exp_src));
        chk("rr_addr", 32'(m_rd_addr), 32'(tbl[n].exp_addr));
      end
      @(posedge clk); #1;
    end
    s_cmd_valid = 4'h0;
    @(posedge clk); #1;

    run_frame(2, 12'h010, 12'd3);
    run_frame(1, 12'hFFE, 12'd3);

    // Backpressure with ready pattern 1,0,0,1.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    s_cmd_addr[0 +: 12] = 12'h200;
    s_cmd_len[0 +: 12]  = 12'd4;
    s_cmd_valid = 4'h1;
    m_rd_ready  = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(s_cmd_ready), 32'h1);
    @(posedge clk); #1;
    s_cmd_valid = 4'h0;
    hs = 0; done = 1'b0; prev_stall = 1'b0;
    prev_addr = '0; prev_src = '0; prev_last = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      m_rd_ready = pat[c % 4];
      @(negedge clk);
      if (!m_rd_valid) begin
        chk("bp_valid_drop", 32'(m_rd_valid), 32'd1);
        done = 1'b1;
      end else begin
        if (prev_stall) begin
          chk("bp_stall_addr", 32'(m_rd_addr), 32'(prev_addr));
          chk("bp_stall_last", 32'(m_rd_last), 32'(prev_last));
          chk("bp_stall_src",  32'(m_rd_src), 32'(prev_src));
        end
        if (m_rd_ready) begin
          chk("bp_addr", 32'(m_rd_addr), 32'(12'h200 + 12'(hs)));
          chk("bp_last", 32'(m_rd_last), 32'(hs == 4));
          if (m_rd_last) done = 1'b1;
          hs++;
        end
        prev_stall = !m_rd_ready;
        prev_addr  = m_rd_addr;
        prev_src   = m_rd_src;
        prev_last  = m_rd_last;
      end
      @(posedge clk); #1;
    end
    chk("bp_handshakes", 32'(hs), 32'd5);
    m_rd_ready = 1'b1;
    @(negedge clk);
    chk("bp_end_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Reset during the third word of an 8-word frame.
    s_cmd_addr[36 +: 12] = 12'h300;
    s_cmd_len[36 +: 12]  = 12'd7;
    s_cmd_valid = 4'h8;
    @(negedge clk);
    chk("mr_accept", 32'(s_cmd_ready), 32'h8);
    @(posedge clk); #1;
    s_cmd_valid = 4'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mr_addr", 32'(m_rd_addr), 32'(12'h300 + 12'(i)));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mr_word3_addr", 32'(m_rd_addr), 32'h302);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_valid", 32'(m_rd_valid), 32'd0);
    chk("mr_busy",  32'(busy), 32'd0);
    chk("mr_grant", 32'(grant_index), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_no_resume", 32'(m_rd_valid), 32'd0);
    @(posedge clk); #1;
    run_frame(1, 12'h050, 12'd1);

    // Fixed priority: sources 1 and 3 always valid, only 1 may ever win.
    fp_valid = 4'hA;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fp_ready != 4'h0) begin
        chk("fp_ready", 32'(fp_ready), 32'h2);
        acc++;
      end
      if (fp_rd_valid) chk("fp_src", 32'(fp_rd_src), 32'd1);
      @(posedge clk); #1;
    end
    chk("fp_accepts", 32'(acc), 32'd5);
    fp_valid = 4'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_ram_switch_rd_sched.md
# axis_ram_switch_rd_sched

Read-side frame scheduler for one output port of the shared-RAM AXI stream switch. It accepts frame read commands from S_COUNT per-source command queues (one virtual FIFO per input), arbitrates between them at frame boundaries, and expands the granted command into a sequence of single-word RAM read requests with wrapping addresses. It sits between the per-input command FIFOs and the RAM read port / output pipeline of one switch output.

## Interface
- S_COUNT, 4, number of requesting sources (1..16)
- ADDR_WIDTH, 12, RAM word address width; addresses wrap modulo 2^ADDR_WIDTH
- LEN_WIDTH, 12, frame length field width; encodes word count minus one
- ARB_TYPE_ROUND_ROBIN, 1, 1 = round robin, 0 = fixed priority
- ARB_LSB_HIGH_PRIORITY, 1, 1 = lower index wins ties / search ascending; 0 = descending
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_cmd_addr  in  S_COUNT*ADDR_WIDTH  per-source frame start address
- s_cmd_len  in  S_COUNT*LEN_WIDTH  per-source frame length minus one
- s_cmd_valid  in  S_COUNT  per-source command valid
- s_cmd_ready  out  S_COUNT  per-source command accept
- m_rd_addr  out  ADDR_WIDTH  RAM read address
- m_rd_src  out  $clog2(S_COUNT) (min 1)  source index of current frame
- m_rd_last  out  1  final word of frame
- m_rd_valid  out  1  read request valid
- m_rd_ready  in  1  read port accept
- busy  out  1  frame in progress
- grant_index  out  $clog2(S_COUNT) (min 1)  last granted source

## Operation
- Two states: IDLE, READ.
- IDLE: arbiter evaluates s_cmd_valid. If any set, selects one source g; s_cmd_ready = one-hot(g), combinational, only in IDLE. On that cycle command is latched: addr_reg <= s_cmd_addr[g], rem_reg <= s_cmd_len[g], src_reg/grant_index <= g, state <= READ.
- No valid in IDLE: s_cmd_ready = 0, stays IDLE.
- READ: m_rd_valid = 1, m_rd_addr = addr_reg, m_rd_src = src_reg, m_rd_last = (rem_reg == 0). On m_rd_valid && m_rd_ready: if rem_reg == 0, state <= IDLE; else addr_reg <= addr_reg + 1 (ADDR_WIDTH bits, wraps 2^ADDR_WIDTH-1 -> 0), rem_reg <= rem_reg - 1.
- m_rd_ready low in READ: all outputs held stable (AXI-stream style, no retraction).
- Round robin: search starts at index after last grant (ascending if ARB_LSB_HIGH_PRIORITY=1, descending otherwise), wrapping; pointer updates only on command acceptance. After reset pointer state is such that index 0 (LSB high) or S_COUNT-1 (LSB low) is searched first.
- Fixed priority: lowest index (LSB high) or highest index wins every time; pointer ignored.
- Commands from non-granted sources are never accepted; a source may drop s_cmd_valid without loss only while its ready is low (upstream FIFO guarantees it does not).
- busy = (state == READ).
- Length: word count = s_cmd_len + 1; max frame 2^LEN_WIDTH words.

## Timing
- Reset: state IDLE, s_cmd_ready 0, m_rd_valid 0, m_rd_last 0, m_rd_addr 0, m_rd_src 0, grant_index 0, busy 0, RR pointer reset.
- Reset mid-frame: frame abandoned, no further read requests; partially issued frame not resumed.
- Command accept to first m_rd_valid: 1 cycle.
- Throughput in READ: one word per cycle while m_rd_ready high.
- Frame boundary: one IDLE bubble cycle between last-word handshake and next command accept; next first word appears 2 cycles after last-word handshake.
- Simultaneous valid from several sources in IDLE: exactly one ready bit set; others wait.

## Test plan
- Single command src 2, addr 0x010, len 3 -> s_cmd_ready[2] one cycle, then 4 reads addr 0x010..0x013, m_rd_src=2, m_rd_last only on 0x013, busy falls after.
- Wrap: addr 0xFFE, len 3 (ADDR_WIDTH 12) -> addresses 0xFFE, 0xFFF, 0x000, 0x001, last on 0x001.
- All 4 sources valid continuously, len 0, round robin LSB high -> grant order 0,1,2,3,0,1; each read 1 word, 2-cycle spacing between frames.
- Fixed priority (ARB_TYPE_ROUND_ROBIN=0), sources 1 and 3 always valid -> source 1 granted every frame, source 3 never accepted.
- Backpressure: len 4, m_rd_ready toggled 1,0,0,1,... -> addr/last/src stable while stalled, exactly 5 handshakes, addresses strictly sequential.
- Reset asserted on 3rd word of 8-word frame -> next cycle m_rd_valid 0, busy 0, grant_index 0; after release, new command accepted normally starting at its own address.
